mesh_term_rx: RTL and testbench

Hardware terminal sink for one port of the `mesh_gnrtr` router mesh. It drains the router's output side of a terminal (`pndng`/`data_out`/`popin`) and decodes the packet header. Packets addressed to this terminal, or broadcast, are buffered in a local first-word-fall-through FIFO for a downstream consumer. Misrouted packets are dropped and counted. It is the receiving end of the terminal interface whose sending end the mesh drives.

---
 rtl/mesh_term_rx.sv | 115 +++++++++++
 tb/tb_mesh_term_rx.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/mesh_term_rx.sv
// rtl/mesh_term_rx.sv - mesh terminal sink: pops router output, filters by address, buffers in a FWFT FIFO
module mesh_term_rx #(
  parameter int          PAKG_SIZE  = 32,
  parameter int          FIFO_DEPTH = 16,
  parameter logic [3:0]  ROW_ID     = 4'd0,
  parameter logic [3:0]  COL_ID     = 4'd0,
  parameter logic [7:0]  BDCST      = 8'hFF
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          pndng,
  input  logic [PAKG_SIZE-1:0]          data_out,
  output logic                          popin,
  input  logic                          rd_en,
  output logic [PAKG_SIZE-1:0]          rd_data,
  output logic                          rd_empty,
  output logic [$clog2(FIFO_DEPTH):0]   rd_count,
  output logic [15:0]                   pkt_count,
  output logic [7:0]                    misroute_count,
  output logic                          err_misroute
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, POP, SETTLE} state_t;

  state_t                 state, state_nxt;
  logic [PAKG_SIZE-1:0]   hold;
  logic [PAKG_SIZE-1:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr, rd_ptr;
  logic                   can_pop, accept;
  logic                   capture, fifo_wr, drop, rd_fire;

  // Space check deliberately uses the registered occupancy, not a same-cycle read.
  assign can_pop = pndng && (rd_count < CW'(FIFO_DEPTH));
  assign accept  = (hold[PAKG_SIZE-1 -: 8] == BDCST) ||
                   ((hold[PAKG_SIZE-9 -: 4] == ROW_ID) && (hold[PAKG_SIZE-13 -: 4] == COL_ID));
  assign rd_empty = (rd_count == '0);
  assign rd_fire  = rd_en && !rd_empty;
  assign rd_data  = mem[rd_ptr];

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (can_pop) state_nxt = POP;
      POP:     state_nxt = SETTLE;
      SETTLE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    capture = 1'b0;
    fifo_wr = 1'b0;
    drop    = 1'b0;
    case (state)
      IDLE:    capture = can_pop;
      POP: begin
        fifo_wr = accept;
        drop    = !accept;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      popin        <= 1'b0;
      err_misroute <= 1'b0;
      hold         <= '0;
    end else begin
      popin        <= capture;
      err_misroute <= drop;
      if (capture) hold <= data_out;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      pkt_count      <= '0;
      misroute_count <= '0;
    end else begin
      if (fifo_wr && pkt_count != 16'hFFFF)    pkt_count      <= pkt_count + 16'd1;
      if (drop && misroute_count != 8'hFF)     misroute_count <= misroute_count + 8'd1;
    end
  end

  // Storage is not reset; pointers and occupancy define what is valid.
  always_ff @(posedge clk_i) begin
    if (fifo_wr) mem[wr_ptr] <= hold;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      rd_count <= '0;
    end else begin
      if (fifo_wr) wr_ptr <= wr_ptr + AW'(1);
      if (rd_fire) rd_ptr <= rd_ptr + AW'(1);
      case ({fifo_wr, rd_fire})
        2'b10:   rd_count <= rd_count + CW'(1);
        2'b01:   rd_count <= rd_count - CW'(1);
        default: rd_count <= rd_count;
      endcase
    end
  end

endmodule

// File: tb/tb_mesh_term_rx.sv
// tb/tb_mesh_term_rx.sv - directed self-checking bench for mesh_term_rx
module tb_mesh_term_rx;

  logic        clk_i = 1'b0;
  logic        rst_i, pndng, rd_en, popin, rd_empty, err_misroute;
  logic [31:0] data_out, rd_data;
  logic [4:0]  rd_count;
  logic [15:0] pkt_count;
  logic [7:0]  misroute_count;
  int          checks = 0;
  int          errors = 0;

  always #5 clk_i = ~clk_i;

  mesh_term_rx #(
    .PAKG_SIZE(32), .FIFO_DEPTH(16), .ROW_ID(4'd2), .COL_ID(4'd3), .BDCST(8'hFF)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .pndng(pndng), .data_out(data_out), .popin(popin),
    .rd_en(rd_en), .rd_data(rd_data), .rd_empty(rd_empty), .rd_count(rd_count),
    .pkt_count(pkt_count), .misroute_count(misroute_count), .err_misroute(err_misroute)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pat(input int i);
    return 32'h0123_0000 | 32'(i);
  endfunction

  // Called at a negedge with the DUT idle; returns at the negedge after the write/drop edge.
  task automatic send_one(input logic [31:0] d);
    pndng = 1'b1;
    data_out = d;
    @(negedge clk_i);
    check("popin_hi", {31'd0, popin}, 32'd1);
    pndng = 1'b0;
    @(negedge clk_i);
    check("popin_lo", {31'd0, popin}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pops, last, idx, seen, errs;
    rst_i = 1'b0; pndng = 1'b0; rd_en = 1'b0; data_out = '0;
    repeat (3) @(negedge clk_i);
    check("rst_popin", {31'd0, popin}, 32'd0);
    check("rst_empty", {31'd0, rd_empty}, 32'd1);
    check("rst_count", {27'd0, rd_count}, 32'd0);
    check("rst_pkt", {16'd0, pkt_count}, 32'd0);
    check("rst_mis", {24'd0, misroute_count}, 32'd0);
    check("rst_err", {31'd0, err_misroute}, 32'd0);
    rst_i = 1'b1;
    @(negedge clk_i);

    send_one(32'h01238005);
    check("acc_empty", {31'd0, rd_empty}, 32'd0);
    check("acc_data", rd_data, 32'h01238005);
    check("acc_pkt", {16'd0, pkt_count}, 32'd1);
    check("acc_err", {31'd0, err_misroute}, 32'd0);
    @(negedge clk_i);
    check("acc_single_pop", {31'd0, popin}, 32'd0);
    rd_en = 1'b1;
    @(negedge clk_i);
    rd_en = 1'b0;
    check("acc_drained", {31'd0, rd_empty}, 32'd1);

    send_one(32'h01318005);
    check("mis_err", {31'd0, err_misroute}, 32'd1);
    check("mis_cnt", {24'd0, misroute_count}, 32'd1);
    check("mis_empty", {31'd0, rd_empty}, 32'd1);
    @(negedge clk_i);
    check("mis_err_pulse", {31'd0, err_misroute}, 32'd0);

    send_one(32'hFF000001);
    check("bc_data", rd_data, 32'hFF000001);
    check("bc_pkt", {16'd0, pkt_count}, 32'd2);
    @(negedge clk_i);
    rd_en = 1'b1;
    @(negedge clk_i);
    rd_en = 1'b0;

    // Backpressure: router always has a packet; fill from pointer 2 so the FIFO wraps.
    pops = 0; last = 0; idx = 0;
    data_out = pat(0);
    pndng = 1'b1;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk_i);
      if (popin) begin
        if (pops > 0) check("pop_gap", 32'(c - last), 32'd3);
        last = c;
        pops++;
        idx++;
        data_out = pat(idx);
      end
    end
    check("bp_pops", 32'(pops), 32'd16);
    check("bp_popin", {31'd0, popin}, 32'd0);
    check("bp_count", {27'd0, rd_count}, 32'd16);
    check("bp_head", rd_data, pat(0));

    rd_en = 1'b1;
    @(negedge clk_i);
    rd_en = 1'b0;
    check("rec_count", {27'd0, rd_count}, 32'd15);
    check("rec_head", rd_data, pat(1));
    seen = 0;
    for (int k = 0; k < 2; k++) begin
      if (seen == 0) begin
        @(negedge clk_i);
        if (popin) seen = 1;
      end
    end
    check("rec_pop", 32'(seen), 32'd1);
    pndng = 1'b0;
    repeat (2) @(negedge clk_i);
    check("rec_full", {27'd0, rd_count}, 32'd16);
    for (int i = 1; i <= 16; i++) begin
      check("order", rd_data, pat(i));
      rd_en = 1'b1;
      @(negedge clk_i);
    end
    rd_en = 1'b0;
    check("drain_empty", {31'd0, rd_empty}, 32'd1);
    check("drain_pkt", {16'd0, pkt_count}, 32'd19);

    // Reset while in POP.
    pndng = 1'b1;
    data_out = 32'h01230042;
    @(negedge clk_i);
    check("mid_in_pop", {31'd0, popin}, 32'd1);
    #1;
    rst_i = 1'b0;
    pndng = 1'b0;
    #1;
    check("mid_popin", {31'd0, popin}, 32'd0);
    check("mid_count", {27'd0, rd_count}, 32'd0);
    check("mid_empty", {31'd0, rd_empty}, 32'd1);
    check("mid_pkt", {16'd0, pkt_count}, 32'd0);
    check("mid_mis", {24'd0, misroute_count}, 32'd0);
    check("mid_err", {31'd0, err_misroute}, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    send_one(32'h01230042);
    check("post_data", rd_data, 32'h01230042);
    check("post_pkt", {16'd0, pkt_count}, 32'd1);
    check("post_count", {27'd0, rd_count}, 32'd1);
    @(negedge clk_i);
    rd_en = 1'b1;
    @(negedge clk_i);
    rd_en = 1'b0;

    errs = 0;
    for (int i = 0; i < 260; i++) begin
      send_one(32'h01318005);
      if (err_misroute) errs++;
      if (i == 253) check("sat_fe", {24'd0, misroute_count}, 32'h000000FE);
      @(negedge clk_i);
    end
    check("sat_ff", {24'd0, misroute_count}, 32'h000000FF);
    check("sat_pulses", 32'(errs), 32'd260);
    check("sat_empty", {31'd0, rd_empty}, 32'd1);
    check("sat_pkt", {16'd0, pkt_count}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
